// File: rtl/vx_fpu_round_sched_pkg.sv
// Shared FPU rounding definitions: rounding-mode encodings, the per-request
// control bundle and the dynamic-mode resolution helper.
package vx_fpu_round_sched_pkg;

    localparam logic [2:0] INST_FRM_RNE = 3'b000;
    localparam logic [2:0] INST_FRM_RTZ = 3'b001;
    localparam logic [2:0] INST_FRM_RDN = 3'b010;
    localparam logic [2:0] INST_FRM_RUP = 3'b011;
    localparam logic [2:0] INST_FRM_RMM = 3'b100;
    localparam logic [2:0] INST_FRM_DYN = 3'b111;

    // Narrow per-request fields; abs and tag are width-parameterised and
    // travel alongside this bundle in the top.
    typedef struct packed {
        logic       sign;
        logic [1:0] rs;
        logic [2:0] rm;
        logic       eff_sub;
    } round_ctrl_t;

    typedef struct packed {
        logic       illegal;
        logic [2:0] mode;
    } rm_res_t;

    // DYN picks the CSR mode; anything outside RNE..RMM falls back to RTZ.
    function automatic rm_res_t resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
        rm_res_t    res;
        logic [2:0] eff;
        eff = (rm == INST_FRM_DYN) ? frm : rm;
        if (eff > INST_FRM_RMM) begin
            res.illegal = 1'b1;
            res.mode    = INST_FRM_RTZ;
        end else begin
            res.illegal = 1'b0;
            res.mode    = eff;
        end
        return res;
    endfunction

endpackage

// File: rtl/vx_fpu_round_sched_rounding.sv
// Combinational rounding unit: applies round/sticky under an already-resolved
// rounding mode and derives the zero/sign/inexact side results.
module vx_fpu_round_sched_rounding
    import vx_fpu_round_sched_pkg::*;
#(
    parameter int DAT_WIDTH = 32
) (
    input  logic [DAT_WIDTH-1:0] abs_value_i,
    input  logic                 sign_i,
    input  logic [1:0]           rs_i,
    input  logic [2:0]           rnd_mode_i,
    input  logic                 eff_sub_i,
    output logic [DAT_WIDTH-1:0] abs_rounded_o,
    output logic                 sign_o,
    output logic                 exact_zero_o,
    output logic                 inexact_o
);

    logic round_up;

    always_comb begin
        round_up = 1'b0;
        case (rnd_mode_i)
            INST_FRM_RNE: round_up = rs_i[1] & (rs_i[0] | abs_value_i[0]);
            INST_FRM_RDN: round_up = (|rs_i) & sign_i;
            INST_FRM_RUP: round_up = (|rs_i) & ~sign_i;
            INST_FRM_RMM: round_up = rs_i[1];
            default:      round_up = 1'b0;
        endcase
    end

    // Carry out of the top bit is dropped; the caller owns exponent carry.
    assign abs_rounded_o = abs_value_i + DAT_WIDTH'(round_up);
    assign exact_zero_o  = (abs_value_i == '0) & (rs_i == 2'b00);
    assign sign_o        = (exact_zero_o & eff_sub_i) ? (rnd_mode_i == INST_FRM_RDN) : sign_i;
    assign inexact_o     = |rs_i;

endmodule

// File: rtl/vx_fpu_round_sched.sv
// Round-robin scheduler that shares one rounding unit among NUM_REQS FPU
// back-ends and registers the result into a valid/ready output stage.
module vx_fpu_round_sched
    import vx_fpu_round_sched_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int DAT_WIDTH = 32,
    parameter int TAG_WIDTH = 8,
    parameter int IDX_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    output logic [NUM_REQS-1:0]           req_ready,
    input  logic [NUM_REQS*DAT_WIDTH-1:0] req_abs_value,
    input  logic [NUM_REQS-1:0]           req_sign,
    input  logic [NUM_REQS*2-1:0]         req_rs,
    input  logic [NUM_REQS*3-1:0]         req_rnd_mode,
    input  logic [NUM_REQS-1:0]           req_eff_sub,
    input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
    input  logic [2:0]                    frm_csr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DAT_WIDTH-1:0]          rsp_abs_value,
    output logic                          rsp_sign,
    output logic                          rsp_exact_zero,
    output logic                          rsp_inexact,
    output logic                          rsp_illegal_rm,
    output logic [IDX_W-1:0]              rsp_req_idx,
    output logic [TAG_WIDTH-1:0]          rsp_tag
);

    logic [DAT_WIDTH-1:0] abs_arr   [NUM_REQS];
    logic [TAG_WIDTH-1:0] tag_arr   [NUM_REQS];
    round_ctrl_t          ctrl_arr  [NUM_REQS];
    logic [IDX_W:0]       cand_sum  [NUM_REQS];
    logic [IDX_W-1:0]     cand_idx  [NUM_REQS];

    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_REQS-1:0]  grant;
    logic                 stage_en;
    logic                 fire;

    logic                 rsp_valid_q, rsp_valid_d;
    logic [DAT_WIDTH-1:0] rsp_abs_q;
    logic                 rsp_sign_q, rsp_exact_zero_q, rsp_inexact_q, rsp_illegal_rm_q;
    logic [IDX_W-1:0]     rsp_req_idx_q;
    logic [TAG_WIDTH-1:0] rsp_tag_q;

    round_ctrl_t          sel_ctrl;
    rm_res_t              sel_rm;
    logic [DAT_WIDTH-1:0] rnd_abs;
    logic                 rnd_sign, rnd_exact_zero, rnd_inexact;

    // Unpack the flat request buses and precompute the wrapped search order
    // starting at the priority pointer.
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
        assign abs_arr[gi]          = req_abs_value[gi*DAT_WIDTH +: DAT_WIDTH];
        assign tag_arr[gi]          = req_tag[gi*TAG_WIDTH +: TAG_WIDTH];
        assign ctrl_arr[gi].sign    = req_sign[gi];
        assign ctrl_arr[gi].rs      = req_rs[gi*2 +: 2];
        assign ctrl_arr[gi].rm      = req_rnd_mode[gi*3 +: 3];
        assign ctrl_arr[gi].eff_sub = req_eff_sub[gi];
        assign cand_sum[gi]         = {1'b0, ptr_q} + (IDX_W+1)'(gi);
        assign cand_idx[gi]         = (cand_sum[gi] >= (IDX_W+1)'(NUM_REQS))
                                    ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_REQS))
                                    : cand_sum[gi][IDX_W-1:0];
    end

    // Walk from the farthest candidate down so the nearest valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign grant     = grant_found ? (NUM_REQS'(1) << grant_idx) : '0;
    assign stage_en  = ~rsp_valid_q | rsp_ready;
    assign req_ready = grant & {NUM_REQS{stage_en & ~reset}};
    assign fire      = |(req_valid & req_ready);

    always_comb begin
        ptr_d = ptr_q;
        if (fire) begin
            ptr_d = (32'(grant_idx) + 1 >= NUM_REQS) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    assign sel_ctrl = ctrl_arr[grant_idx];
    assign sel_rm   = resolve_rm(sel_ctrl.rm, frm_csr);

    vx_fpu_round_sched_rounding #(
        .DAT_WIDTH (DAT_WIDTH)
    ) u_rounding (
        .abs_value_i   (abs_arr[grant_idx]),
        .sign_i        (sel_ctrl.sign),
        .rs_i          (sel_ctrl.rs),
        .rnd_mode_i    (sel_rm.mode),
        .eff_sub_i     (sel_ctrl.eff_sub),
        .abs_rounded_o (rnd_abs),
        .sign_o        (rnd_sign),
        .exact_zero_o  (rnd_exact_zero),
        .inexact_o     (rnd_inexact)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        if (fire) begin
            rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q            <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_abs_q        <= '0;
            rsp_sign_q       <= 1'b0;
            rsp_exact_zero_q <= 1'b0;
            rsp_inexact_q    <= 1'b0;
            rsp_illegal_rm_q <= 1'b0;
            rsp_req_idx_q    <= '0;
            rsp_tag_q        <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            if (fire) begin
                rsp_abs_q        <= rnd_abs;
                rsp_sign_q       <= rnd_sign;
                rsp_exact_zero_q <= rnd_exact_zero;
                rsp_inexact_q    <= rnd_inexact;
                rsp_illegal_rm_q <= sel_rm.illegal;
                rsp_req_idx_q    <= grant_idx;
                rsp_tag_q        <= tag_arr[grant_idx];
            end
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_abs_value  = rsp_abs_q;
    assign rsp_sign       = rsp_sign_q;
    assign rsp_exact_zero = rsp_exact_zero_q;
    assign rsp_inexact    = rsp_inexact_q;
    assign rsp_illegal_rm = rsp_illegal_rm_q;
    assign rsp_req_idx    = rsp_req_idx_q;
    assign rsp_tag        = rsp_tag_q;

endmodule

// File: tb/tb_vx_fpu_round_sched.sv
// Directed bench for the shared rounding scheduler (4 requesters, 8-bit data).
module tb_vx_fpu_round_sched;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TW = 8;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] DYN = 3'b111;

    logic           clk = 1'b0;
    logic           reset;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR*DW-1:0] req_abs_value;
    logic [NR-1:0]  req_sign;
    logic [NR*2-1:0] req_rs;
    logic [NR*3-1:0] req_rnd_mode;
    logic [NR-1:0]  req_eff_sub;
    logic [NR*TW-1:0] req_tag;
    logic [2:0]     frm_csr;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [DW-1:0]  rsp_abs_value;
    logic           rsp_sign;
    logic           rsp_exact_zero;
    logic           rsp_inexact;
    logic           rsp_illegal_rm;
    logic [1:0]     rsp_req_idx;
    logic [TW-1:0]  rsp_tag;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    vx_fpu_round_sched #(
        .NUM_REQS  (NR),
        .DAT_WIDTH (DW),
        .TAG_WIDTH (TW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_abs_value  (req_abs_value),
        .req_sign       (req_sign),
        .req_rs         (req_rs),
        .req_rnd_mode   (req_rnd_mode),
        .req_eff_sub    (req_eff_sub),
        .req_tag        (req_tag),
        .frm_csr        (frm_csr),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_abs_value  (rsp_abs_value),
        .rsp_sign       (rsp_sign),
        .rsp_exact_zero (rsp_exact_zero),
        .rsp_inexact    (rsp_inexact),
        .rsp_illegal_rm (rsp_illegal_rm),
        .rsp_req_idx    (rsp_req_idx),
        .rsp_tag        (rsp_tag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] abs, input logic s, input logic [1:0] rs,
                           input logic [2:0] rm, input logic es, input logic [7:0] tag);
        req_abs_value[i*DW +: DW] = abs;
        req_sign[i]               = s;
        req_rs[i*2 +: 2]          = rs;
        req_rnd_mode[i*3 +: 3]    = rm;
        req_eff_sub[i]            = es;
        req_tag[i*TW +: TW]       = tag;
    endtask

    always @(posedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            $display("rsp idx=%0d tag=0x%02h abs=0x%02h sign=%0b ez=%0b nx=%0b ill=%0b",
                     rsp_req_idx, rsp_tag, rsp_abs_value, rsp_sign, rsp_exact_zero,
                     rsp_inexact, rsp_illegal_rm);
        end
    end

    initial begin
        reset         = 1'b1;
        req_valid     = '1;
        req_abs_value = '0;
        req_sign      = '0;
        req_rs        = '0;
        req_rnd_mode  = '0;
        req_eff_sub   = '0;
        req_tag       = '0;
        frm_csr       = RNE;
        rsp_ready     = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_abs", 32'(rsp_abs_value), 0);
        check("rst_tag", 32'(rsp_tag), 0);
        check("rst_ready", 32'(req_ready), 0);
        req_valid = '0;
        reset     = 1'b0;

        // RNE tie to even, odd LSB rounds up
        set_req(0, 8'h05, 1'b0, 2'b10, RNE, 1'b0, 8'hA0);
        req_valid = 4'b0001;
        #1;
        check("rne_ready", 32'(req_ready), 32'h1);
        tick();
        check("rne_valid", 32'(rsp_valid), 1);
        check("rne_abs_odd", 32'(rsp_abs_value), 32'h06);
        check("rne_nx_odd", 32'(rsp_inexact), 1);
        check("rne_idx", 32'(rsp_req_idx), 0);
        check("rne_tag", 32'(rsp_tag), 32'hA0);
        // Even LSB stays; pointer is at 1 so the wrap search still finds req0
        set_req(0, 8'h04, 1'b0, 2'b10, RNE, 1'b0, 8'hA1);
        tick();
        check("rne_abs_even", 32'(rsp_abs_value), 32'h04);
        check("rne_nx_even", 32'(rsp_inexact), 1);
        check("rne_valid_b2b", 32'(rsp_valid), 1);

        // DYN resolves to RDN: negative inexact rounds up
        frm_csr = RDN;
        set_req(1, 8'h10, 1'b1, 2'b01, DYN, 1'b0, 8'hB1);
        req_valid = 4'b0010;
        tick();
        check("dyn_idx", 32'(rsp_req_idx), 1);
        check("dyn_abs", 32'(rsp_abs_value), 32'h11);
        check("dyn_ill", 32'(rsp_illegal_rm), 0);
        check("dyn_sign", 32'(rsp_sign), 1);
        // Reserved CSR mode falls back to truncation and flags illegal
        frm_csr = 3'b101;
        tick();
        check("ill_abs", 32'(rsp_abs_value), 32'h10);
        check("ill_flag", 32'(rsp_illegal_rm), 1);

        // Exact zero under effective subtraction
        set_req(2, 8'h00, 1'b0, 2'b00, RDN, 1'b1, 8'hC2);
        req_valid = 4'b0100;
        tick();
        check("ez_rdn_flag", 32'(rsp_exact_zero), 1);
        check("ez_rdn_sign", 32'(rsp_sign), 1);
        check("ez_rdn_nx", 32'(rsp_inexact), 0);
        set_req(2, 8'h00, 1'b1, 2'b00, RNE, 1'b1, 8'hC3);
        tick();
        check("ez_rne_flag", 32'(rsp_exact_zero), 1);
        check("ez_rne_sign", 32'(rsp_sign), 0);
        // Magnitude wrap on round-up from all ones
        set_req(2, 8'hFF, 1'b0, 2'b11, RNE, 1'b0, 8'hC4);
        tick();
        check("wrap_abs", 32'(rsp_abs_value), 32'h00);
        check("wrap_ez", 32'(rsp_exact_zero), 0);
        check("wrap_tag", 32'(rsp_tag), 32'hC4);

        // Drain with nothing requesting
        req_valid = '0;
        tick();
        check("drain_valid", 32'(rsp_valid), 0);

        // Round-robin from a fresh reset with everyone requesting
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 8'h40 + 8'(i), 1'b0, 2'b00, RTZ, 1'b0, 8'h30 + 8'(i));
        req_valid = '1;
        for (int n = 0; n < 6; n++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(4'b0001 << (n % NR)));
            tick();
            check("rr_idx", 32'(rsp_req_idx), 32'(n % NR));
            check("rr_tag", 32'(rsp_tag), 32'h30 + 32'(n % NR));
        end

        // Backpressure: result from req1 must hold for 3 cycles
        rsp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("bp_ready", 32'(req_ready), 0);
            tick();
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_idx", 32'(rsp_req_idx), 1);
            check("bp_abs", 32'(rsp_abs_value), 32'h41);
            check("bp_tag", 32'(rsp_tag), 32'h31);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'h4);
        tick();
        check("bp_release_valid", 32'(rsp_valid), 1);
        check("bp_release_idx", 32'(rsp_req_idx), 2);

        // Reset with a pending result and req2 about to be granted
        req_valid = 4'b0100;
        reset = 1'b1;
        #1;
        check("midrst_ready", 32'(req_ready), 0);
        tick();
        check("midrst_valid", 32'(rsp_valid), 0);
        check("midrst_abs", 32'(rsp_abs_value), 0);
        reset     = 1'b0;
        req_valid = '1;
        #1;
        check("midrst_first_ready", 32'(req_ready), 32'h1);
        tick();
        check("midrst_first_idx", 32'(rsp_req_idx), 0);
        check("midrst_first_valid", 32'(rsp_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vx_fpu_round_sched.md
Name: vx_fpu_round_sched

Overview:
- Shared-rounding scheduler for the FPU: NUM_REQS producer units (add, mul, fma, div/sqrt, cvt) share one rounding datapath.
- Each requester presents an unrounded magnitude with round/sticky bits and a rounding mode.
- A round-robin arbiter picks one requester and resolves dynamic rounding mode against the frm CSR. It rounds through the combinational rounding sub-unit and registers the result into a valid/ready output stage.
- Sits between the FPU unit back-ends and the FPU writeback mux.

Parameters:
- NUM_REQS, 4, number of requesting units (>=1).
- DAT_WIDTH, 32, magnitude width without sign bit.
- TAG_WIDTH, 8, opaque tag carried with each request.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_ready  out  NUM_REQS  per-requester accept; at most one bit high per cycle.
- req_abs_value  in  NUM_REQS*DAT_WIDTH  unrounded magnitudes, requester i at slice i.
- req_sign  in  NUM_REQS  signs.
- req_rs  in  NUM_REQS*2  round/sticky bits {R,S}.
- req_rnd_mode  in  NUM_REQS*3  rounding mode; 3'b111 = DYN.
- req_eff_sub  in  NUM_REQS  effective-subtraction flag.
- req_tag  in  NUM_REQS*TAG_WIDTH  tags.
- frm_csr  in  3  dynamic rounding mode from the CSR.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_abs_value  out  DAT_WIDTH  rounded magnitude.
- rsp_sign  out  1  result sign.
- rsp_exact_zero  out  1  exact-zero result.
- rsp_inexact  out  1  R or S was nonzero (NX flag).
- rsp_illegal_rm  out  1  the resolved rounding mode was invalid.
- rsp_req_idx  out  max(1,$clog2(NUM_REQS))  index of the granted requester.
- rsp_tag  out  TAG_WIDTH  tag of the granted requester.

Behaviour:
- Reset:
  - rsp_valid=0; all other rsp_* outputs=0.
  - Round-robin pointer=0 (requester 0 has highest priority).
  - req_ready=0 during reset.
- Stage enable: stage_en = ~rsp_valid | rsp_ready.
- Arbitration:
  - grant = first req_valid bit at or after the pointer, searching upward with wrap.
  - req_ready[i] = grant[i] & stage_en; purely combinational, with no dependence on req_ready.
- Handshake fire: any req_valid & req_ready.
  - On fire, the output register loads the rounded result, tag and index, and rsp_valid=1.
  - The pointer moves to (granted index + 1) mod NUM_REQS.
- Pointer hold: the pointer does not change when nothing fires, including stalls.
- Output drain: if rsp_ready & rsp_valid and nothing fires, rsp_valid goes to 0.
- Latency and throughput: 1 cycle, request fire to rsp_valid. Full throughput: back-to-back fires while rsp_ready=1.
- Stall: when rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable and no req_ready is asserted.
- Mode resolution:
  - Effective mode is frm_csr if req_rnd_mode==3'b111, else req_rnd_mode.
  - If the effective mode is 5, 6 or 7, rounding uses RTZ and rsp_illegal_rm=1.
  - Illegal mode never propagates X.
- Rounding (sub-unit), on the winning requester:
  - RNE: round up if RS=11, or RS=10 with LSB=1.
  - RTZ: never round up.
  - RDN: round up if RS!=0 and sign=1.
  - RUP: round up if RS!=0 and sign=0.
  - RMM: round up if R=1.
  - abs_rounded = abs + round_up, modulo 2^DAT_WIDTH. Wrap is intentional; exponent carry is the caller's encoding.
  - exact_zero = (abs==0) & (RS==0).
  - sign = (exact_zero & eff_sub) ? (mode==RDN) : sign_in.
  - inexact = |RS.
- No valid requesters: no fire; pointer and output are unchanged, apart from the drain rule.
- A requester that drops valid without being granted is legal; it is simply not considered.
- NUM_REQS=1: arbiter degenerates to pass-through; rsp_req_idx=0.
- Reset mid-operation: any in-flight result is discarded, rsp_valid=0 the next cycle, and the pointer returns to 0.

Decomposition:
- Shared FPU package (VX_fpu_define.vh / FPU pkg) holds:
  - rounding-mode constants INST_FRM_RNE/RTZ/RDN/RUP/RMM/DYN;
  - a round-request struct {abs, sign, rs, rm, eff_sub, tag}.
- Sub-module: the existing combinational rounding unit VX_fpu_rounding, instantiated once on the arbiter's mux output.
- Arbiter is local logic; it may reuse the codebase's generic round-robin arbiter if one with this priority-pointer semantic exists.

Test Plan:
- RNE tie to even (DAT_WIDTH=8, NUM_REQS=4): req0 abs=0x05 RS=10 rm=RNE → rsp_abs=0x06, inexact=1. abs=0x04 RS=10 → 0x04, inexact=1.
- Round-robin fairness: all 4 req_valid held high, rsp_ready=1 → rsp_req_idx sequence 0,1,2,3,0,1 on consecutive cycles; exactly one req_ready per cycle.
- Backpressure: a result is pending and rsp_ready=0 for 3 cycles → rsp_* stable and req_ready=0 throughout. rsp_ready=1 → the next grant fires the same cycle and rsp_valid stays 1.
- DYN and illegal mode:
  - frm_csr=RDN, rm=3'b111, sign=1, abs=0x10, RS=01 → rsp_abs=0x11, illegal_rm=0.
  - frm_csr=3'b101, same request → rsp_abs=0x10 (RTZ), illegal_rm=1.
- Exact zero and wrap:
  - abs=0 RS=00 eff_sub=1 rm=RDN → exact_zero=1, sign=1; with rm=RNE → sign=0.
  - abs=0xFF RS=11 RNE → rsp_abs=0x00.
- Reset mid-stream: reset asserted while rsp_valid=1 and req2 granted next → rsp_valid=0 the next cycle. After release with all requesters valid, the first grant is idx 0.
